// File: rtl/m_axi_burst_engine.sv
// AXI4 master burst engine: splits one stream command into INCR bursts that
// respect MAX_BURST and 4 KB boundaries, keeping one burst in flight at a time.
module m_axi_burst_engine #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                m_axi_aclk,
    input  logic                m_axi_areset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [15:0]         cmd_beats,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);

    localparam int BYTES     = DATA_W / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WDATA = 3'd2,
        S_WRESP = 3'd3,
        S_RADDR = 3'd4,
        S_RDATA = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         remain_q, remain_d;
    logic [8:0]          beat_cnt_q, beat_cnt_d;
    logic                err_q, err_d;
    logic                live_q;

    logic [12:0]         page_beats_s;
    logic [8:0]          rem_clip_s;
    logic [8:0]          burst_beats_s;
    logic                last_beat_s;
    logic                unused_s;

    assign unused_s = ^{m_axi_bresp[0], m_axi_rresp[0]};

    // Burst size: smallest of beats left, MAX_BURST and beats left in the 4 KB page.
    always_comb begin
        page_beats_s = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE_LOG2;
        if (remain_q > 16'(MAX_BURST)) begin
            rem_clip_s = 9'(MAX_BURST);
        end else begin
            rem_clip_s = remain_q[8:0];
        end
        if ({4'd0, rem_clip_s} > page_beats_s) begin
            burst_beats_s = page_beats_s[8:0];
        end else begin
            burst_beats_s = rem_clip_s;
        end
    end

    assign last_beat_s = (beat_cnt_q == 9'd1);

    // Next-state and datapath update for the command/burst sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d   = cmd_addr & ~ADDR_W'(BYTES - 1);
                    remain_d = cmd_beats;
                    err_d    = 1'b0;
                    if (cmd_beats == 16'd0) begin
                        state_d = S_DONE;
                    end else if (cmd_write) begin
                        state_d = S_WADDR;
                    end else begin
                        state_d = S_RADDR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WADDR, S_RADDR: begin
                if ((state_q == S_WADDR) ? m_axi_awready : m_axi_arready) begin
                    addr_d     = addr_q + (ADDR_W'(burst_beats_s) << SIZE_LOG2);
                    remain_d   = remain_q - {7'd0, burst_beats_s};
                    beat_cnt_d = burst_beats_s;
                    state_d    = (state_q == S_WADDR) ? S_WDATA : S_RDATA;
                end else begin
                    state_d = state_q;
                end
            end
            S_WDATA: begin
                if (wr_valid && m_axi_wready) begin
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    state_d    = last_beat_s ? S_WRESP : S_WDATA;
                end else begin
                    state_d = S_WDATA;
                end
            end
            S_WRESP: begin
                if (m_axi_bvalid) begin
                    err_d   = err_q | m_axi_bresp[1];
                    state_d = (remain_q != 16'd0) ? S_WADDR : S_DONE;
                end else begin
                    state_d = S_WRESP;
                end
            end
            S_RDATA: begin
                // A misplaced or missing rlast only flags; the local count decides burst end.
                if (m_axi_rvalid && rd_ready) begin
                    beat_cnt_d = beat_cnt_q - 9'd1;
                    err_d      = err_q | m_axi_rresp[1] | (m_axi_rlast != last_beat_s);
                    if (last_beat_s) begin
                        state_d = (remain_q != 16'd0) ? S_RADDR : S_DONE;
                    end else begin
                        state_d = S_RDATA;
                    end
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; live_q keeps cmd_ready low until the first edge after reset.
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q    <= S_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            remain_q   <= 16'd0;
            beat_cnt_q <= 9'd0;
            err_q      <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            live_q     <= 1'b1;
        end
    end

    assign cmd_ready     = (state_q == S_IDLE) && live_q;

    assign m_axi_awvalid = (state_q == S_WADDR);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(burst_beats_s - 9'd1);

    assign m_axi_wvalid  = (state_q == S_WDATA) && wr_valid;
    assign wr_ready      = (state_q == S_WDATA) && m_axi_wready;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = {(DATA_W/8){1'b1}};
    assign m_axi_wlast   = (state_q == S_WDATA) && last_beat_s;
    assign m_axi_bready  = (state_q == S_WRESP);

    assign m_axi_arvalid = (state_q == S_RADDR);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(burst_beats_s - 9'd1);

    assign rd_valid      = (state_q == S_RDATA) && m_axi_rvalid;
    assign rd_data       = m_axi_rdata;
    assign m_axi_rready  = (state_q == S_RDATA) && rd_ready;

    assign done          = (state_q == S_DONE);
    assign err           = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_m_axi_burst_engine.sv
// Randomised bench for m_axi_burst_engine: a reactive AXI slave and stream
// endpoints, checked against a burst-splitting model computed from plain arithmetic.
`timescale 1ns/1ps
module tb_m_axi_burst_engine;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            m_axi_areset;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [15:0]     cmd_beats;
    logic [DW-1:0]   wr_data, rd_data;
    logic            wr_valid, wr_ready, rd_valid, rd_ready, done, err;
    logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
    logic [7:0]      m_axi_awlen, m_axi_arlen;
    logic            m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
    logic [DW/8-1:0] m_axi_wstrb;
    logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]      m_axi_bresp, m_axi_rresp;
    logic            m_axi_bvalid, m_axi_bready;
    logic            m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] seen_addr[$];
    int          seen_len[$];

    always #5 clk = ~clk;

    m_axi_burst_engine #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .m_axi_aclk(clk), .m_axi_areset(m_axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .err(err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rmem(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_1234;
    endfunction

    function automatic logic rnd_on(input bit gaps);
        return !gaps || ($urandom_range(0, 3) != 0);
    endfunction

    task automatic idle_inputs();
        cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = 32'd0;
    endtask

    // One command end to end. resp_err_b / rlast_err_b pick a burst that gets an
    // error response / early rlast (-1 = none). rst_mid aborts it with reset in WDATA.
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input int beats, input bit gaps,
                           input int resp_err_b, input int rlast_err_b, input bit exp_err,
                           input bit rst_mid);
        logic [31:0] ea[$];
        int          el[$];
        logic [31:0] exp_rd[$];
        logic [31:0] wseq[$];
        logic [31:0] rq_d[$];
        logic        rq_l[$];
        logic [1:0]  rq_r[$];
        logic [1:0]  bq[$];
        logic [31:0] a, aw_h_addr, ar_h_addr;
        logic [7:0]  aw_h_len, ar_h_len;
        int rem, n, room, cyc, acc_cyc, done_cyc, nburst, closed;
        int wr_idx, wcnt, wbeat, rd_idx, done_cnt, ax_cycles;
        bit accepted, fin, aw_hold, ar_hold, rv_hold, bv_hold;

        a = addr & ~32'd3;
        rem = beats;
        while (rem > 0) begin
            room = (4096 - int'(a & 32'hFFF)) / 4;
            n = (rem < MB) ? rem : MB;
            if (n > room) n = room;
            ea.push_back(a);
            el.push_back(n - 1);
            for (int i = 0; i < n; i++) exp_rd.push_back(rmem(a + 32'(i * 4)));
            a = a + 32'(n * 4);
            rem -= n;
        end
        for (int i = 0; i < beats; i++) wseq.push_back($urandom);
        seen_addr.delete();
        seen_len.delete();
        cyc = 0; acc_cyc = 0; done_cyc = 0; nburst = 0; closed = 0;
        wr_idx = 0; wcnt = 0; wbeat = 0; rd_idx = 0; done_cnt = 0; ax_cycles = 0;
        accepted = 0; fin = 0; aw_hold = 0; ar_hold = 0; rv_hold = 0; bv_hold = 0;
        aw_h_addr = 32'd0; ar_h_addr = 32'd0; aw_h_len = 8'd0; ar_h_len = 8'd0;

        while (!fin) begin
            @(negedge clk);
            cmd_valid     = !accepted;
            cmd_write     = wr;
            cmd_addr      = addr;
            cmd_beats     = 16'(beats);
            m_axi_awready = rnd_on(gaps);
            m_axi_arready = rnd_on(gaps);
            m_axi_wready  = rnd_on(gaps);
            rd_ready      = rnd_on(gaps);
            wr_valid      = (wr_idx < beats) && rnd_on(gaps);
            wr_data       = (wr_idx < beats) ? wseq[wr_idx] : 32'd0;
            m_axi_bvalid  = (bq.size() > 0) && (bv_hold || rnd_on(gaps));
            m_axi_bresp   = (bq.size() > 0) ? bq[0] : 2'b00;
            m_axi_rvalid  = (rq_d.size() > 0) && (rv_hold || rnd_on(gaps));
            m_axi_rdata   = (rq_d.size() > 0) ? rq_d[0] : 32'd0;
            m_axi_rlast   = (rq_d.size() > 0) ? rq_l[0] : 1'b0;
            m_axi_rresp   = (rq_d.size() > 0) ? rq_r[0] : 2'b00;
            #1;

            if (rst_mid && wr_idx >= 2 && wr_ready) begin
                #1 m_axi_areset = 1'b1;
                #1 check("rst_mid_outputs",
                         {cmd_ready, wr_ready, rd_valid, done, err, m_axi_awvalid, m_axi_wvalid,
                          m_axi_bready, m_axi_arvalid, m_axi_rready}, 10'd0);
                @(negedge clk);
                idle_inputs();
                m_axi_areset = 1'b0;
                #1 check("rst_mid_ready_low", cmd_ready, 1'b0);
                @(posedge clk);
                #1 check("rst_mid_ready_rise", cmd_ready, 1'b1);
                return;
            end

            if (aw_hold) check("aw_stable", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, {1'b1, aw_h_addr, aw_h_len});
            if (ar_hold) check("ar_stable", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, ar_h_addr, ar_h_len});
            aw_hold = m_axi_awvalid && !m_axi_awready;
            ar_hold = m_axi_arvalid && !m_axi_arready;
            aw_h_addr = m_axi_awaddr; aw_h_len = m_axi_awlen;
            ar_h_addr = m_axi_araddr; ar_h_len = m_axi_arlen;
            if (m_axi_awvalid || m_axi_arvalid) ax_cycles++;

            if (cmd_valid && cmd_ready) begin
                accepted = 1;
                acc_cyc = cyc;
            end

            if (m_axi_bvalid && m_axi_bready) begin
                void'(bq.pop_front());
                closed++;
            end
            bv_hold = m_axi_bvalid && !m_axi_bready;

            if (rd_valid && rd_ready) begin
                if (rd_idx < exp_rd.size()) check("rd_data", rd_data, exp_rd[rd_idx]);
                else check("rd_extra", rd_idx, exp_rd.size());
                rd_idx++;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                void'(rq_d.pop_front()); void'(rq_l.pop_front()); void'(rq_r.pop_front());
                if (rq_d.size() == 0) closed++;
            end
            rv_hold = m_axi_rvalid && !m_axi_rready;

            if (m_axi_awvalid && m_axi_awready) begin
                check("aw_one_outstanding", closed, nburst);
                if (nburst < ea.size()) begin
                    check("aw_addr", m_axi_awaddr, ea[nburst]);
                    check("aw_len", m_axi_awlen, el[nburst]);
                end else check("aw_extra", nburst, ea.size());
                seen_addr.push_back(m_axi_awaddr);
                seen_len.push_back(int'(m_axi_awlen));
                nburst++;
                wbeat = 0;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                check("ar_one_outstanding", closed, nburst);
                if (nburst < ea.size()) begin
                    check("ar_addr", m_axi_araddr, ea[nburst]);
                    check("ar_len", m_axi_arlen, el[nburst]);
                end else check("ar_extra", nburst, ea.size());
                seen_addr.push_back(m_axi_araddr);
                seen_len.push_back(int'(m_axi_arlen));
                for (int i = 0; i <= int'(m_axi_arlen); i++) begin
                    rq_d.push_back(rmem(m_axi_araddr + 32'(i * 4)));
                    if (nburst == rlast_err_b && m_axi_arlen != 8'd0) rq_l.push_back(i == 0);
                    else rq_l.push_back(i == int'(m_axi_arlen));
                    rq_r.push_back((nburst == resp_err_b && i == 0) ? 2'b10 : 2'b00);
                end
                nburst++;
            end

            if (m_axi_wvalid && m_axi_wready) begin
                if (wcnt < beats) check("w_data", m_axi_wdata, wseq[wcnt]);
                else check("w_extra", wcnt, beats);
                check("w_strb", m_axi_wstrb, 4'hF);
                if (nburst > 0) check("w_last", m_axi_wlast, wbeat == el[nburst - 1]);
                if (m_axi_wlast) bq.push_back((nburst - 1 == resp_err_b) ? 2'b10 : 2'b00);
                wbeat++;
                wcnt++;
            end
            if (wr_valid && wr_ready) wr_idx++;

            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_err", err, exp_err);
                fin = 1;
            end
            cyc++;
            if (cyc > 3000) begin
                check("timeout", 1'b0, 1'b1);
                fin = 1;
            end
        end

        @(negedge clk);
        idle_inputs();
        #1;
        check("done_one_cycle", done, 1'b0);
        check("ready_after_done", cmd_ready, 1'b1);
        check("done_count", done_cnt, 1);
        check("burst_count", nburst, ea.size());
        if (beats == 0) begin
            check("zero_done_latency", done_cyc - acc_cyc, 1);
            check("zero_no_axvalid", ax_cycles, 0);
        end
        if (wr) check("w_beats", wcnt, beats);
        else check("rd_beats", rd_idx, beats);
    endtask

    initial begin
        logic [31:0] ra;
        idle_inputs();
        cmd_write = 1'b0; cmd_addr = 32'd0; cmd_beats = 16'd0;
        wr_data = 32'd0;
        m_axi_areset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {cmd_ready, wr_ready, rd_valid, done, err, m_axi_awvalid, m_axi_wvalid,
               m_axi_bready, m_axi_arvalid, m_axi_rready}, 10'd0);
        @(negedge clk);
        m_axi_areset = 1'b0;
        #1 check("reset_ready_low", cmd_ready, 1'b0);
        @(posedge clk);
        #1 check("reset_ready_rise", cmd_ready, 1'b1);

        run_cmd(1'b1, 32'h0000_0FE0, 20, 1'b1, -1, -1, 1'b0, 1'b0);
        check("fe0_bursts", seen_addr.size(), 2);
        if (seen_addr.size() == 2) begin
            check("fe0_a0", seen_addr[0], 32'h0FE0); check("fe0_l0", seen_len[0], 7);
            check("fe0_a1", seen_addr[1], 32'h1000); check("fe0_l1", seen_len[1], 11);
        end

        run_cmd(1'b0, 32'h0000_0100, 40, 1'b1, -1, -1, 1'b0, 1'b0);
        check("r100_bursts", seen_addr.size(), 3);
        if (seen_addr.size() == 3) begin
            check("r100_a0", seen_addr[0], 32'h100); check("r100_l0", seen_len[0], 15);
            check("r100_a1", seen_addr[1], 32'h140); check("r100_l1", seen_len[1], 15);
            check("r100_a2", seen_addr[2], 32'h180); check("r100_l2", seen_len[2], 7);
        end

        run_cmd(1'b1, 32'h0000_2000, 20, 1'b1, 0, -1, 1'b1, 1'b0);
        check("berr_bursts", seen_addr.size(), 2);
        run_cmd(0, 32'h0000_3000, 5, 1'b1, -1, -1, 1'b0, 1'b0);
        run_cmd(1'b1, 32'h0000_0040, 0, 1'b1, -1, -1, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_0040, 0, 1'b1, -1, -1, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_0FF0, 12, 1'b1, 1, -1, 1'b1, 1'b0);
        run_cmd(1'b0, 32'h0000_0500, 20, 1'b1, -1, 0, 1'b1, 1'b0);
        run_cmd(1'b1, 32'hFFFF_FFF0, 8, 1'b1, -1, -1, 1'b0, 1'b0);
        run_cmd(1'b0, 32'h0000_0107, 3, 1'b1, -1, -1, 1'b0, 1'b0);
        check("unaligned_addr", seen_addr.size() > 0 ? seen_addr[0] : 32'hDEAD, 32'h104);

        for (int k = 0; k < 12; k++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) != 0) ra[11:0] = 12'hFFC - 12'($urandom_range(0, 50) * 4);
            run_cmd(1'($urandom_range(0, 1)), ra, $urandom_range(1, 70), 1'b1, -1, -1, 1'b0, 1'b0);
        end

        run_cmd(1'b1, 32'h0000_0FE0, 20, 1'b0, -1, -1, 1'b0, 1'b1);
        run_cmd(1'b0, 32'h0000_0080, 4, 1'b1, -1, -1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/m_axi_burst_engine.md
M_AXI_BURST_ENGINE -- requirements
Module: m_axi_burst_engine

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width; DATA_W, 32, data width (power of two, >=8); MAX_BURST, 16, max beats per burst (1..256).
REQ-002 SHALL have ports:
- m_axi_aclk, in, 1, sole clock.
- m_axi_areset, in, 1, asynchronous active-high reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, engine idle and accepting a command.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_addr, in, ADDR_W, start byte address.
- cmd_beats, in, 16, total beats.
- wr_data, in, DATA_W, write stream data.
- wr_valid, in, 1, write stream valid.
- wr_ready, out, 1, write stream ready.
- rd_data, out, DATA_W, read stream data.
- rd_valid, out, 1, read stream valid.
- rd_ready, in, 1, read stream ready.
- done, out, 1, one-cycle command-complete pulse.
- err, out, 1, error status, valid with done.
- m_axi_awaddr/awlen/awvalid, out, ADDR_W/8/1, AW channel.
- m_axi_awready, in, 1.
- m_axi_wdata/wstrb/wlast/wvalid, out, DATA_W/DATA_W/8/1/1, W channel.
- m_axi_wready, in, 1.
- m_axi_bresp/bvalid, in, 2/1; m_axi_bready, out, 1.
- m_axi_araddr/arlen/arvalid, out, ADDR_W/8/1, AR channel.
- m_axi_arready, in, 1.
- m_axi_rdata/rresp/rlast/rvalid, in, DATA_W/2/1/1; m_axi_rready, out, 1.
REQ-003 SHALL treat AxSIZE as log2(DATA_W/8) and AxBURST as INCR, both unported; wstrb SHALL be all ones.

Function
REQ-004 SHALL use states IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE; cmd_ready = (state==IDLE).
REQ-005 On cmd handshake SHALL latch the command with addr low log2(DATA_W/8) bits forced to 0, then go to WADDR (write) or RADDR (read); cmd_beats==0 SHALL go directly to DONE with no AXI traffic.
REQ-006 Per burst, beats SHALL be min(remaining, MAX_BURST, (4096 - addr[11:0])/(DATA_W/8)); AxLEN = beats-1; no burst SHALL cross a 4 KB boundary.
REQ-007 AxVALID SHALL hold with stable addr/len until AxREADY; then state goes to WDATA/RDATA and addr += beats*DATA_W/8 (mod 2^ADDR_W).
REQ-008 Exactly one burst SHALL be outstanding; the next AW/AR SHALL not issue before the prior B response / rlast handshake.
REQ-009 In WDATA: wvalid = wr_valid, wr_ready = wready, wdata = wr_data combinationally; wlast high on the burst's final beat; the wlast handshake goes to WRESP. wr_ready SHALL be 0 outside WDATA.
REQ-010 In WRESP: bready = 1; on bvalid, bresp[1]=1 SHALL set the sticky error flag; next state WADDR if remaining > 0, else DONE.
REQ-011 In RDATA: rd_valid = rvalid, rd_data = rdata, rready = rd_ready; each handshake decrements the burst count; rresp[1]=1 sets the sticky error flag.
REQ-012 rlast arriving before, or missing on, the burst's final counted beat SHALL set the error flag; the burst ends on the counted final beat.
REQ-013 DONE SHALL last one cycle: done = 1, err = sticky flag; then IDLE, with the flag cleared on the next command accept.
REQ-014 Errors SHALL NOT abort a command; all bursts still issue.

Reset
REQ-015 While m_axi_areset is high, all valids, readies, done, err and cmd_ready SHALL be 0 and state SHALL be IDLE, asynchronously and including mid-burst; cmd_ready SHALL rise the first cycle after release.

Verification
REQ-016 Cover:
- Write, addr 0x0FE0, beats 20, DATA_W 32 -> bursts 0x0FE0/len 7 then 0x1000/len 11; 20 wr beats consumed; done with err=0.
- Read, addr 0x100, beats 40 -> AR 0x100/15, 0x140/15, 0x180/7; 40 rd_data beats in order; one done pulse.
- Write of 2 bursts, first bresp=2'b10 -> second burst still issued; done with err=1; next clean command gives err=0.
- cmd_beats=0 -> done the cycle after accept, err=0, no AW/AR valid.
- Random wr_valid/rd_ready/awready gaps -> no data loss; valids stable until handshake.
- Reset asserted in WDATA -> all outputs 0 immediately; cmd_ready=1 one cycle after release.
